// File: rtl/spi_slave_rx_fsm.sv
// SPI slave receiver (CPOL=0, CPHA=0, MSB first) for an SPI clock asynchronous to clk.
// Inputs are synchronized, sclk rising edges are detected, and completed words are handed over with a valid/ack handshake.
module spi_slave_rx_fsm #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic [DATA_W-1:0] rx_dat,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              overrun,
  output logic              frame_err,
  output logic              busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-2:0] shift_q, shift_d;
  logic [DATA_W-1:0] rx_dat_q, rx_dat_d;
  logic              rx_valid_q, rx_valid_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;

  logic              sclk_s, ss_s, mosi_s, sclk_rise;
  logic [DATA_W-1:0] word;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign word      = {shift_q, mosi_s};

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_s;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rx_dat_d    = rx_dat_q;
    rx_valid_d  = rx_valid_q & ~rx_ack;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!ss_s) begin
          state_d = RECV;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      RECV: begin
        // Deselect wins over a coincident sclk edge; a partial word is dropped.
        if (ss_s) begin
          state_d     = IDLE;
          frame_err_d = (cnt_q != '0);
        end else if (sclk_rise) begin
          shift_d = word[DATA_W-2:0];
          if (cnt_q == LAST_BIT) begin
            cnt_d      = '0;
            rx_dat_d   = word;
            rx_valid_d = 1'b1;
            overrun_d  = rx_valid_q & ~rx_ack;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      rx_dat_q    <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rx_dat_q    <= rx_dat_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_dat    = rx_dat_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == RECV);

endmodule

// File: tb/tb_spi_slave_rx_fsm.sv
// Bench for spi_slave_rx_fsm: directed scenarios plus randomized frames checked
// against a word-level model of what the receiver should hand over.
module tb_spi_slave_rx_fsm;

  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              sclk = 1'b0;
  logic              ss = 1'b1;
  logic              mosi = 1'b0;
  logic              rx_ack = 1'b0;
  logic [DATA_W-1:0] rx_dat;
  logic              rx_valid, overrun, frame_err, busy;

  spi_slave_rx_fsm #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi),
    .rx_dat(rx_dat), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .overrun(overrun), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse-cycle and valid-rise counters observed on the falling edge.
  int   ovr_cycles = 0;
  int   fe_cycles = 0;
  int   valid_rises = 0;
  logic valid_prev = 1'b0;
  always @(negedge clk) begin
    if (overrun === 1'b1) ovr_cycles <= ovr_cycles + 1;
    if (frame_err === 1'b1) fe_cycles <= fe_cycles + 1;
    if (rx_valid === 1'b1 && valid_prev !== 1'b1) valid_rises <= valid_rises + 1;
    valid_prev <= rx_valid;
  end

  // Word-level reference model.
  logic [DATA_W-1:0] exp_dat = '0;
  logic              exp_valid = 1'b0;
  int                exp_ovr = 0;
  int                exp_fe = 0;

  task automatic model_word(input logic [DATA_W-1:0] w, input bit ack_same_edge);
    if (exp_valid && !ack_same_edge) exp_ovr++;
    exp_dat   = w;
    exp_valid = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_partial(input logic [DATA_W-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = w[DATA_W-1-i];
      tick(5);
      sclk = 1'b1;
      tick(5);
      sclk = 1'b0;
    end
  endtask

  // Leaves sclk high, four clk edges after the last rising edge.
  task automatic send_word_rise(input logic [DATA_W-1:0] w);
    send_partial(w, DATA_W - 1);
    mosi = w[0];
    tick(5);
    sclk = 1'b1;
    tick(4);
  endtask

  task automatic sclk_fall();
    tick(1);
    sclk = 1'b0;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic frame_start();
    ss = 1'b0;
    tick(6);
  endtask

  task automatic frame_end();
    tick(5);
    ss = 1'b1;
    tick(8);
  endtask

  task automatic check_word(input string name);
    checks++;
    if (rx_dat !== exp_dat || rx_valid !== exp_valid) begin
      errors++;
      $display("FAIL %s: rx_dat=%h rx_valid=%b, expected %h %b", name, rx_dat, rx_valid, exp_dat, exp_valid);
    end
  endtask

  task automatic check_pulses(input string name);
    checks++;
    if (ovr_cycles != exp_ovr || fe_cycles != exp_fe) begin
      errors++;
      $display("FAIL %s: overrun cycles=%0d frame_err cycles=%0d, expected %0d %0d", name, ovr_cycles, fe_cycles, exp_ovr, exp_fe);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({rx_dat, rx_valid, overrun, frame_err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_async: outputs=%h, expected 0", {rx_dat, rx_valid, overrun, frame_err, busy});
    end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if ({rx_dat, rx_valid, overrun, frame_err, busy} !== '0) begin
        errors++;
        $display("FAIL reset_hold: outputs=%h, expected 0", {rx_dat, rx_valid, overrun, frame_err, busy});
      end
    end
    rst = 1'b1;
    tick(6);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_single();
    frame_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: busy=%b, expected 1", busy);
    end
    send_word_rise(8'h55);
    model_word(8'h55, 1'b0);
    check_word("single_word");
    sclk_fall();
    frame_end();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b, expected 0", busy);
    end
    check_pulses("single_pulses");
  endtask

  task automatic test_back_to_back();
    int r0;
    pulse_ack();
    tick(2);
    r0 = valid_rises;
    frame_start();
    send_word_rise(8'hA5);
    model_word(8'hA5, 1'b0);
    check_word("b2b_first");
    sclk_fall();
    pulse_ack();
    send_word_rise(8'h3C);
    model_word(8'h3C, 1'b0);
    check_word("b2b_second");
    sclk_fall();
    frame_end();
    checks++;
    if (valid_rises - r0 != 2) begin
      errors++;
      $display("FAIL b2b_valid_rises: got %0d, expected 2", valid_rises - r0);
    end
    check_pulses("b2b_pulses");
  endtask

  task automatic test_overrun();
    pulse_ack();
    frame_start();
    send_word_rise(8'h12);
    model_word(8'h12, 1'b0);
    check_word("ovr_first");
    sclk_fall();
    send_word_rise(8'h34);
    model_word(8'h34, 1'b0);
    check_word("ovr_second");
    sclk_fall();
    frame_end();
    check_pulses("ovr_pulses");
  endtask

  task automatic test_frame_err();
    frame_start();
    send_partial(8'hC3, 5);
    exp_fe++;
    frame_end();
    check_word("fe_unchanged");
    check_pulses("fe_pulse");
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL fe_busy: busy=%b, expected 0", busy);
    end
    frame_start();
    frame_end();
    check_pulses("fe_empty_frame");
  endtask

  task automatic test_reset_mid_word();
    frame_start();
    send_partial(8'hA0, 4);
    rst = 1'b0;
    #1;
    checks++;
    if ({rx_dat, rx_valid, overrun, frame_err, busy} !== '0) begin
      errors++;
      $display("FAIL midrst_async: outputs=%h, expected 0", {rx_dat, rx_valid, overrun, frame_err, busy});
    end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if ({rx_dat, rx_valid, overrun, frame_err, busy} !== '0) begin
        errors++;
        $display("FAIL midrst_hold: outputs=%h, expected 0", {rx_dat, rx_valid, overrun, frame_err, busy});
      end
    end
    rst = 1'b1;
    exp_dat   = '0;
    exp_valid = 1'b0;
    tick(6);
    send_word_rise(8'hF0);
    model_word(8'hF0, 1'b0);
    check_word("midrst_word");
    sclk_fall();
    frame_end();
    check_pulses("midrst_pulses");
  endtask

  task automatic test_simul_ack();
    logic [DATA_W-1:0] w1, w2;
    bit seen;
    w1 = DATA_W'($urandom);
    w2 = w1 ^ DATA_W'($urandom_range(1, 255));
    frame_start();
    send_word_rise(w1);
    model_word(w1, 1'b0);
    check_word("simul_first");
    sclk_fall();
    send_partial(w2, DATA_W - 1);
    mosi = w2[0];
    tick(5);
    sclk = 1'b1;
    // The word cannot complete before the synchronizer has passed the edge.
    repeat (SYNC_STAGES) @(posedge clk);
    #1;
    rx_ack = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rx_dat === w2) begin
        seen = 1'b1;
        break;
      end
    end
    rx_ack = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL simul_timeout: rx_dat=%h, expected %h within bound", rx_dat, w2);
    end
    model_word(w2, 1'b1);
    @(posedge clk);
    #1;
    tick(2);
    sclk = 1'b0;
    check_word("simul_second");
    frame_end();
    check_pulses("simul_pulses");
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] w;
    int nw;
    for (int f = 0; f < 12; f++) begin
      frame_start();
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) begin
        w = DATA_W'($urandom);
        send_word_rise(w);
        model_word(w, 1'b0);
        check_word("rand_word");
        sclk_fall();
        if ($urandom_range(0, 1) == 1) pulse_ack();
      end
      if ($urandom_range(0, 3) == 0) begin
        send_partial(DATA_W'($urandom), $urandom_range(1, DATA_W - 1));
        exp_fe++;
      end
      frame_end();
      check_word("rand_frame_end");
      check_pulses("rand_pulses");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_reset_mid_word();
    test_simul_ack();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx_fsm.md
SPI_SLAVE_RX_FSM -- requirements
Module: spi_slave_rx_fsm

Interface
REQ-001 Parameter DATA_W, default 8: bits per SPI word.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2: synchronizer flops on sclk, ss and mosi.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-005 sclk  input  1  SPI clock from master, asynchronous to clk.
REQ-006 ss  input  1  slave select from master, active-low.
REQ-007 mosi  input  1  serial data from master.
REQ-008 rx_dat  output  DATA_W  last completed received word.
REQ-009 rx_valid  output  1  rx_dat holds an unconsumed word.
REQ-010 rx_ack  input  1  consumer handshake; clears rx_valid.
REQ-011 overrun  output  1  one-clk pulse: word completed while previous word unconsumed.
REQ-012 frame_err  output  1  one-clk pulse: ss deasserted with a partial word.
REQ-013 busy  output  1  high while FSM is in RECV.

Function
REQ-014 SPI mode SHALL be CPOL=0, CPHA=0, MSB first; mosi sampled on sclk rising edge.
REQ-015 sclk, ss and mosi SHALL each pass through SYNC_STAGES flops before use; no raw input drives FSM or datapath logic.
REQ-016 A sclk rising edge SHALL be detected as synchronized sclk=1 while the previous synchronized sample was 0; a falling edge is ignored.
REQ-017 Correct operation SHALL require sclk high and low phases of at least 3 clk periods each.
REQ-018 FSM states SHALL be IDLE and RECV.
REQ-019 IDLE -> RECV when synchronized ss=0; on entry, clear the bit counter and shift register.
REQ-020 RECV -> IDLE when synchronized ss=1.
REQ-021 In RECV, on each detected sclk rising edge: shift synchronized mosi into the LSB of the shift register, then increment the bit counter.
REQ-022 Edges detected in IDLE SHALL be ignored.
REQ-023 When the DATA_W-th bit shifts in, on that same clk edge:
  - load {shift[DATA_W-2:0], mosi} into rx_dat;
  - set rx_valid;
  - wrap the counter to 0;
  - stay in RECV, so back-to-back words are supported.
REQ-024 From the DATA_W-th raw sclk rising edge to rx_valid=1, latency SHALL be SYNC_STAGES+2 clk cycles or fewer.
REQ-025 rx_valid SHALL stay high until a clk edge where rx_ack=1; it clears then unless a word completes on that same edge.
REQ-026 rx_ack while rx_valid=0 SHALL have no effect.
REQ-027 Word completes while rx_valid=1 and rx_ack=0:
  - overwrite rx_dat with the new word;
  - keep rx_valid=1;
  - pulse overrun for one cycle.
REQ-028 Word completes on the same edge as rx_ack=1: load the new word, keep rx_valid=1, no overrun.
REQ-029 ss deasserts in RECV with bit counter nonzero:
  - pulse frame_err for one cycle;
  - discard the partial word;
  - leave rx_dat and rx_valid unchanged.
REQ-030 ss deasserts with bit counter 0: no frame_err.
REQ-031 A sclk edge and ss deassertion detected on the same cycle SHALL be resolved as deassertion; the edge is ignored.
REQ-032 busy SHALL equal (state==RECV).

Reset
REQ-033 While rst=0, regardless of clk:
  - state=IDLE; counter, shift register and synchronizers = 0, except the ss synchronizer = 1;
  - rx_dat=0, rx_valid=0, overrun=0, frame_err=0, busy=0.
REQ-034 rst asserted mid-word SHALL abort the word with no frame_err.
REQ-035 After rst deasserts, the first word SHALL be received only after ss is seen high-then-low, or low at release; either way, counting starts from bit 0.

Verification
REQ-036 Single word: ss low, 8 sclk pulses (period 10 clk) carrying 0x55 MSB-first, ss high -> rx_dat=0x55, rx_valid=1 within 4 clk of 8th rise, no overrun, no frame_err.
REQ-037 Back-to-back: 0xA5 then 0x3C under one ss, rx_ack pulsed after the first -> rx_dat=0xA5 then 0x3C, two rx_valid assertions, overrun=0.
REQ-038 Overrun: 0x12 then 0x34 with no rx_ack -> overrun pulses once at the second completion, rx_dat=0x34, rx_valid=1.
REQ-039 Frame error: ss low, 5 sclk pulses, ss high -> frame_err one-cycle pulse, rx_valid and rx_dat unchanged, busy=0.
REQ-040 Reset mid-word: rst low after 4 bits for 3 clk, then a full 0xF0 frame -> all outputs 0 during reset, no frame_err, rx_dat=0xF0 afterward.
REQ-041 Simultaneous ack: rx_ack=1 on the completion edge of the second word -> rx_valid stays 1, overrun=0, rx_dat holds the second word.
